// File: rtl/word_gate_ctl_pkg.sv
// Shared timing constants and FSM state type for the drum word gate.
// Included by every word_gate_ctl file via import timing_pkg::*.
package timing_pkg;

  localparam int WORDS_PER_REV = 108;
  localparam int BITS_PER_WORD = 29;

  typedef logic [6:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER,
    DONE
  } wg_state_t;

endpackage

// File: rtl/word_gate_ctl_if.sv
// Request handshake between command sequencer and word gate.
// master = sequencer side, slave = word_gate_ctl side.
interface word_gate_if #(
  parameter int WBITS = 7
);

  logic             req;
  logic [WBITS-1:0] start_word;
  logic [WBITS-1:0] end_word;
  logic             dbl;
  logic             abort;
  logic             ack;
  logic             req_err;
  logic             busy;

  modport master (
    output req, start_word, end_word, dbl, abort,
    input  ack, req_err, busy
  );

  modport slave (
    input  req, start_word, end_word, dbl, abort,
    output ack, req_err, busy
  );

endinterface

// File: rtl/word_gate_ctl_counter.sv
// Drum word counter, index sync and optional index-slip check.
// Slip check enabled by WORD_GATE_SYNC_CHECK_EN.
module word_counter
  import timing_pkg::*;
#(
  parameter int WORDS = WORDS_PER_REV,
  parameter int WBITS = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t0,
  input  logic             t29,
  output logic [WBITS-1:0] word_count,
  output logic             synced,
  output logic             sync_err,
  output logic             slip
);

  localparam logic [WBITS-1:0] LAST = WBITS'(WORDS - 1);

  logic last_w;

  assign last_w = (word_count == LAST);

`ifdef WORD_GATE_SYNC_CHECK_EN
  assign slip = t0 && synced && !last_w;

  // Index seen away from word 107: latch the fault until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_err <= 1'b0;
    end else if (slip) begin
      sync_err <= 1'b1;
    end
  end
`else
  assign slip     = 1'b0;
  assign sync_err = 1'b0;
`endif

  // Advance on each word's last bit; index forces word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_count <= '0;
      synced     <= 1'b0;
    end else if (t0) begin
      word_count <= '0;
      synced     <= 1'b1;
    end else if (t29) begin
      word_count <= last_w ? '0 : word_count + 1'b1;
    end
  end

endmodule

// File: rtl/word_gate_ctl.sv
// Drum word-time scheduler: waits for start word, gates through end word.
// Optional index-slip check: WORD_GATE_SYNC_CHECK_EN.
module word_gate_ctl
  import timing_pkg::*;
#(
  parameter int WORDS = 108,
  parameter int WBITS = 7
) (
  input  logic             CLOCK,
  input  logic             rst,
  input  logic             T0,
  input  logic             T1,
  input  logic             T29,
  word_gate_if.slave       bus,
  output logic             xfer,
  output logic             done,
  output logic [WBITS-1:0] word_count,
  output logic             synced,
  output logic             sync_err
);

  localparam logic [WBITS-1:0] LAST = WBITS'(WORDS - 1);

  wg_state_t        state;
  logic [WBITS-1:0] s_q;
  logic [WBITS-1:0] e_q;
  logic [WBITS-1:0] s_in;
  logic [WBITS-1:0] e_in;
  logic [WBITS-1:0] nxt;
  logic             ack_q;
  logic             err_q;
  logic             busy_q;
  logic             xfer_q;
  logic             done_q;
  logic             bad;
  logic             slip;
  logic             unused;

  // Gating is word-aligned off T29, so T1 carries no extra information.
  assign unused = T1;

  word_counter #(
    .WORDS (WORDS),
    .WBITS (WBITS)
  ) u_cnt (
    .clk        (CLOCK),
    .rst        (rst),
    .t0         (T0),
    .t29        (T29),
    .word_count (word_count),
    .synced     (synced),
    .sync_err   (sync_err),
    .slip       (slip)
  );

  assign bad  = (bus.start_word > LAST) || (bus.end_word > LAST);
  assign s_in = bus.dbl ? {bus.start_word[WBITS-1:1], 1'b0}
                        : bus.start_word;
  assign e_in = bus.dbl ? (bus.end_word | WBITS'(1)) : bus.end_word;
  assign nxt  = (word_count == LAST) ? '0 : word_count + 1'b1;

  assign bus.ack     = ack_q;
  assign bus.req_err = err_q;
  assign bus.busy    = busy_q;
  assign xfer        = xfer_q;
  assign done        = done_q;

  // Request accept, start-word wait, gate window and done pulse.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state  <= IDLE;
      s_q    <= '0;
      e_q    <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      xfer_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
      if (bus.abort) begin
        state  <= IDLE;
        busy_q <= 1'b0;
        xfer_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            // err_q blocks a second look at a req still held this cycle
            if (bus.req && synced && !err_q) begin
              if (bad) begin
                err_q <= 1'b1;
              end else begin
                s_q    <= s_in;
                e_q    <= e_in;
                ack_q  <= 1'b1;
                busy_q <= 1'b1;
                state  <= WAIT;
              end
            end
          end
          WAIT: begin
            if (T29 && nxt == s_q) begin
              xfer_q <= 1'b1;
              state  <= XFER;
            end
          end
          XFER: begin
            if (slip) begin
              xfer_q <= 1'b0;
              busy_q <= 1'b0;
              state  <= IDLE;
            end else if (T29 && word_count == e_q) begin
              xfer_q <= 1'b0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_word_gate_ctl.sv
// Scoreboard bench for word_gate_ctl driven by a T0/T1/T29 drum model.
// Define WORD_GATE_SYNC_CHECK_EN to also exercise the index-slip check.
module tb_word_gate_ctl;

  localparam int NW   = 108;
  localparam int NB   = 29;
  localparam int NPOS = NW * NB;

  logic       clk = 1'b0;
  logic       rst;
  logic       T0, T1, T29;
  logic       xfer, done, synced, sync_err;
  logic [6:0] word_count;

  always #5 clk = ~clk;

  word_gate_if #(.WBITS(7)) bus ();

  word_gate_ctl #(
    .WORDS (108),
    .WBITS (7)
  ) dut (
    .CLOCK      (clk),
    .rst        (rst),
    .T0         (T0),
    .T1         (T1),
    .T29        (T29),
    .bus        (bus),
    .xfer       (xfer),
    .done       (done),
    .word_count (word_count),
    .synced     (synced),
    .sync_err   (sync_err)
  );

  typedef struct {
    bit is_err;
    int first;
    int ncyc;
    int kill;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  int nvec = 0;
  int nfail = 0;
  int pos;
  int cyc;
  bit inj_arm  = 1'b0;
  bit inj_pres = 1'b0;
  bit jump     = 1'b0;

  bit mon_en     = 1'b0;
  bit exp_synced = 1'b0;
  bit exp_serr   = 1'b0;
  bit xfer_prev  = 1'b0;
  bit abort_prev = 1'b0;
  bit armed      = 1'b0;
  int run        = 0;
  int exp_rise   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, act, want, cyc);
    end
  endtask

  function automatic int pmod(input int a, input int m);
    return ((a % m) + m) % m;
  endfunction

  task automatic drive_pos();
    int w;
    int b;
    w   = pos / NB;
    b   = pos % NB;
    T1  = (b == 0);
    T29 = (b == NB - 1);
    inj_pres = inj_arm && T29 && (w == 50);
    T0  = (T29 && w == NW - 1) || inj_pres;
    if (inj_pres) begin
      inj_arm = 1'b0;
      jump    = 1'b1;
    end
  endtask

  // drum: inputs change 1 after each rising edge
  initial begin
    pos = $urandom_range(60, 90) * NB;
    cyc = 0;
    drive_pos();
    forever begin
      @(posedge clk);
      #1;
      if (jump) begin
        pos  = 0;
        jump = 1'b0;
      end else begin
        pos = (pos + 1) % NPOS;
      end
      cyc++;
      drive_pos();
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (pos % NB == 0) begin
        chk("synced", synced, exp_synced);
        if (exp_synced) chk("word_count", word_count, pos / NB);
        chk("sync_err", sync_err, exp_serr);
      end
      if (bus.ack && bus.req_err) chk("ack_and_err", 1, 0);
      if (bus.ack || bus.req_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_handshake", 1, 0);
        end else begin
          cur = exp_q[0];
          chk("hs_kind_err", bus.req_err, cur.is_err);
          chk("busy_at_hs", bus.busy, !cur.is_err);
          if (cur.is_err) begin
            void'(exp_q.pop_front());
          end else begin
            exp_rise = cyc + 1 + pmod(cur.first * NB - pos - 1, NPOS);
            armed    = 1'b1;
          end
        end
      end
      if (xfer && !xfer_prev) begin
        run = 0;
        if (!armed) chk("xfer_unexpected", 1, 0);
        else        chk("rise_cycle", cyc, exp_rise);
      end
      if (xfer) run++;
      if (!xfer && xfer_prev) begin
        armed = 1'b0;
        if (exp_q.size() == 0) begin
          chk("fall_unexpected", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          chk("xfer_len", run, cur.ncyc);
          chk("done_at_fall", done, cur.kill == 0);
          chk("busy_at_fall", bus.busy, 0);
          if (cur.kill == 1) chk("abort_prev", abort_prev, 1);
        end
      end else if (done) begin
        chk("done_unexpected", 1, 0);
      end
      if (rst) begin
        exp_synced = 1'b0;
        exp_serr   = 1'b0;
      end else begin
        if (inj_pres && exp_synced) exp_serr = 1'b1;
        if (T0) exp_synced = 1'b1;
      end
      xfer_prev  = xfer;
      abort_prev = bus.abort;
    end
  end

  task automatic issue(input int s, input int e, input bit d,
                       input int at_word, input int kill,
                       input int kw, input int kb);
    exp_t x;
    int   last;
    int   lat;
    int   t;
    @(posedge clk);
    #2;
    x.is_err = (s >= NW) || (e >= NW);
    x.first  = d ? (s & ~1) : s;
    last     = d ? (e | 1) : e;
    x.ncyc   = NB * (pmod(last - x.first, NW) + 1);
    x.kill   = kill;
    if (kill == 1) x.ncyc = NB * pmod(kw - x.first, NW) + kb + 1;
    if (kill == 2) x.ncyc = NB * (pmod(50 - x.first, NW) + 1);
    if (at_word >= 0) begin
      t = 0;
      while (pos / NB != at_word && t < NPOS + 10) begin
        @(posedge clk);
        #2;
        t++;
      end
    end
    exp_q.push_back(x);
    bus.start_word = 7'(s);
    bus.end_word   = 7'(e);
    bus.dbl        = d;
    bus.req        = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(bus.ack || bus.req_err) && lat < 40);
    chk("hs_negedges", lat, 2);
    if (!(bus.ack || bus.req_err)) exp_q.delete();
    @(posedge clk);
    #2;
    bus.req = 1'b0;
    if (kill != 0 && !x.is_err) begin
      t = 0;
      while (!xfer && t < 2 * NPOS) begin
        @(posedge clk);
        #2;
        t++;
      end
      if (kill == 1) begin
        while (pos != kw * NB + kb && t < 3 * NPOS) begin
          @(posedge clk);
          #2;
          t++;
        end
        bus.abort = 1'b1;
        @(posedge clk);
        #2;
        bus.abort = 1'b0;
      end else begin
        inj_arm = 1'b1;
      end
    end
    t = 0;
    while (exp_q.size() != 0 && t < 3 * NPOS) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk("txn_complete", exp_q.size(), 0);
    if (exp_q.size() != 0) begin
      exp_q.delete();
      armed = 1'b0;
    end
  endtask

  initial begin
    int acks;
    int t;
    rst            = 1'b1;
    bus.req        = 1'b0;
    bus.start_word = '0;
    bus.end_word   = '0;
    bus.dbl        = 1'b0;
    bus.abort      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", bus.ack, 0);
    chk("rst_req_err", bus.req_err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_xfer", xfer, 0);
    chk("rst_done", done, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_synced", synced, 0);
    chk("rst_sync_err", sync_err, 0);
    @(posedge clk);
    #2;
    rst    = 1'b0;
    mon_en = 1'b1;

    // request held before any index pulse
    bus.start_word = 7'd10;
    bus.end_word   = 7'd12;
    bus.req        = 1'b1;
    acks = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.ack || bus.req_err) acks++;
    end
    chk("presync_ack", acks, 0);
    chk("presync_synced", synced, 0);
    @(posedge clk);
    #2;
    bus.req = 1'b0;

    t = 0;
    while (!synced && t < NPOS + 100) begin
      @(negedge clk);
      t++;
    end
    chk("sync_acquired", synced, 1);
    chk("sync_at_word0_t1", pos, 0);
    chk("sync_word_count", word_count, 0);

    issue(10, 12, 0, 5, 0, 0, 0);
    issue(106, 1, 0, -1, 0, 0, 0);
    issue(7, 8, 1, -1, 0, 0, 0);
    issue(108, 20, 0, -1, 0, 0, 0);
    issue(10, 20, 0, -1, 1, 11, 5);
`ifdef WORD_GATE_SYNC_CHECK_EN
    issue(40, 60, 0, -1, 2, 0, 0);
    chk("sync_err_set", sync_err, 1);
`else
    chk("sync_err_idle", sync_err, 0);
`endif
    for (int i = 0; i < 5; i++) begin
      int s;
      int e;
      bit d;
      s = $urandom_range(0, 111);
      e = $urandom_range(0, 111);
      d = 1'($urandom_range(0, 1));
      issue(s, e, d, -1, 0, 0, 0);
    end
    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/word_gate_ctl.md
# word_gate_ctl

Drum word-time scheduler for the G-15 timing subsystem. Tracks the current drum word (0–107) from the bit-time pulses produced by the timing gates. Accepts transfer requests naming a start and end word, waits for the drum to reach the start word, then asserts a word-aligned transfer gate through the end word. It sits between the command sequencer and the line/accumulator transfer gating.

## Interface
Parameters:
- WORDS, 108, word times per drum revolution
- WBITS, 7, width of word-number fields

Ports:
- CLOCK  in  1  bit-time clock (9.3 µs)
- rst  in  1  reset, synchronous, active-high
- T0  in  1  T29 of word 107 (index)
- T1  in  1  first bit time of every word
- T29  in  1  last bit time of every word
- req  in  1  transfer request, level, held until ack or req_err
- start_word  in  WBITS  first word of transfer
- end_word  in  WBITS  last word of transfer
- dbl  in  1  double-precision request (word pairs)
- abort  in  1  cancel transfer in progress
- ack  out  1  one-cycle pulse, request accepted
- req_err  out  1  one-cycle pulse, request rejected (out of range)
- busy  out  1  request latched, not yet done
- xfer  out  1  transfer gate, T1..T29 of each word in window
- done  out  1  one-cycle pulse after last gated word
- word_count  out  WBITS  current drum word
- synced  out  1  word_count valid
- sync_err  out  1  sticky index mismatch (macro only)

## Operation
- Word counter: on a T29 cycle, word_count ← word_count+1, wrapping 107→0. T0 forces word_count ← 0 and sets synced. The value is stable T1..T29 of the word it names.
- FSM states: IDLE, WAIT, XFER, DONE.
- IDLE:
  - If req && synced: when start_word>107 or end_word>107, pulse req_err and stay in IDLE. Otherwise latch s/e, pulse ack, go to WAIT.
  - When !synced, req stays pending with no ack.
- dbl: latched s ← start_word & ~1, e ← end_word | 1.
- WAIT → XFER on a T29 cycle where (word_count+1) mod 108 == s. A request accepted mid-word of word s waits one full revolution (no partial words).
- XFER: xfer=1. On a T29 cycle where word_count == e, go to DONE.
  - e < s: the window wraps 107→0.
  - e == s: one word.
- DONE: done=1 for one cycle, then IDLE. busy = (state≠IDLE), deasserted in the DONE cycle.
- abort: in any state, → IDLE next cycle. No done pulse; xfer drops next cycle. abort wins over a simultaneous req or transition.
- ack and req_err are mutually exclusive.

## Timing
- Reset values:
  - state IDLE
  - word_count 0
  - synced 0
  - ack/req_err/busy/xfer/done 0
  - sync_err 0
- Reset mid-transfer: identical to the reset values above; synced must re-acquire on the next T0.
- All outputs are registered.
- ack is the cycle after req is sampled in IDLE.
- xfer rises on the T1 cycle of word s and falls after the T29 cycle of word e. It covers exactly 29·N cycles, where N = ((e−s) mod 108)+1.
- done is the cycle following the last T29 of the window, i.e. the T1 cycle of word e+1.
- Worst-case wait is 108 words (3132 cycles).
- A new req can be accepted in the cycle after done.

## Configuration
- WORD_GATE_SYNC_CHECK_EN defined:
  - When T0 arrives with synced=1 and word_count≠107, sync_err is set (sticky until rst).
  - word_count is still forced to 0.
  - An active XFER goes to IDLE without done.
- Undefined: sync_err tied 0; T0 silently resyncs.

## Structure
- timing_pkg:
  - WORDS_PER_REV=108, BITS_PER_WORD=29
  - typedef word_t (logic [6:0])
  - enum wg_state_t {IDLE, WAIT, XFER, DONE}
- Sub-module word_counter holds word_count, synced and the optional index check. The FSM stays in word_gate_ctl.

## Test plan
- Reset, then a T0-driven stimulus model (29 bits × 108 words). Check synced rises at the first T0 and word_count reads 0 at the next T1. Check req held before sync gets no ack.
- req start=10, end=12, with word_count=5: ack next cycle; xfer on T1 of word 10 for exactly 87 cycles; done once.
- Wrap: start=106, end=1: xfer covers words 106,107,0,1 = 116 cycles.
- dbl start=7, end=8: gated words 6..9 (116 cycles). start=108: req_err, no ack, busy stays 0.
- abort during XFER at word 11 of a 10..20 window: xfer=0 next cycle, no done, IDLE.
- With WORD_GATE_SYNC_CHECK_EN, inject T0 at word 50: sync_err=1, word_count=0, active transfer dropped. Without the macro, sync_err stays 0.
